// File: rtl/endpoint_rx_fsm.sv
// Receive-side packet engine: parses flit headers, streams payload words into the RX cache
// ring buffer and queues one descriptor per completed packet until software releases it.
module endpoint_rx_fsm #(
  parameter int BUF_WORDS     = 128,
  parameter int NUM_MSGS      = 4,
  parameter int MAX_PKT_WORDS = 64,
  localparam int AW           = $clog2(BUF_WORDS)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic [4:0]    node_id,
  input  logic          flit_valid,
  input  logic [31:0]   flit_data,
  output logic          flit_ready,
  output logic          buf_wen,
  output logic [AW-1:0] buf_waddr,
  output logic [31:0]   buf_wdata,
  output logic          desc_valid,
  output logic [AW-1:0] desc_start,
  output logic [6:0]    desc_len,
  output logic [4:0]    desc_src,
  input  logic          desc_release,
  output logic [7:0]    drop_count,
  output logic          err_pulse
);

  localparam int FW = $clog2(NUM_MSGS);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DROP} state_t;

  typedef struct packed {
    logic [AW-1:0] start;
    logic [6:0]    len;
    logic [4:0]    src;
  } desc_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   used_q, used_d;
  logic [6:0]    rem_q, rem_d;
  desc_t         cur_q, cur_d;
  desc_t         fifo_q [NUM_MSGS];
  logic [FW-1:0] rd_q, rd_d, wp_q, wp_d;
  logic [FW:0]   cnt_q, cnt_d;
  logic [7:0]    drop_q, drop_d;
  logic          err_q, err_d;

  logic [4:0]  h_dest, h_src;
  logic [6:0]  h_len;
  logic        bad_len, fifo_full, fifo_empty, room;
  logic [AW:0] free_w;
  logic        hdr_acc, hdr_bad, hdr_drop, pl_wr, push, pop;
  desc_t       head;
  logic        unused_hdr;

  assign h_dest     = flit_data[27:23];
  assign h_src      = flit_data[22:18];
  assign h_len      = flit_data[17:11];
  assign unused_hdr = ^{flit_data[31:28], flit_data[10:0]};

  assign bad_len    = (h_len == 7'd0) || (h_len > 7'(MAX_PKT_WORDS));
  assign fifo_full  = (cnt_q == (FW+1)'(NUM_MSGS));
  assign fifo_empty = (cnt_q == '0);
  assign free_w     = (AW+1)'(BUF_WORDS) - used_q;
  // Space for the whole packet is reserved when its header is taken, so payload never stalls.
  assign room       = (32'(free_w) >= 32'(h_len)) && !fifo_full;
  assign head       = fifo_q[rd_q];

  always_comb begin
    state_d    = state_q;
    flit_ready = 1'b0;
    hdr_acc    = 1'b0;
    hdr_bad    = 1'b0;
    hdr_drop   = 1'b0;
    pl_wr      = 1'b0;
    push       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flit_valid) begin
          if (bad_len) begin
            flit_ready = 1'b1;
            hdr_bad    = 1'b1;
          end else if (h_dest != node_id) begin
            flit_ready = 1'b1;
            hdr_drop   = 1'b1;
            state_d    = S_DROP;
          end else if (room) begin
            flit_ready = 1'b1;
            hdr_acc    = 1'b1;
            state_d    = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        flit_ready = 1'b1;
        if (flit_valid) begin
          pl_wr = 1'b1;
          if (rem_q == 7'd1) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_DROP: begin
        flit_ready = 1'b1;
        if (flit_valid && rem_q == 7'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pop = desc_release && !fifo_empty;

  always_comb begin
    rem_d    = rem_q;
    cur_d    = cur_q;
    wr_ptr_d = wr_ptr_q;
    if (hdr_acc || hdr_drop) rem_d = h_len;
    else if (state_q != S_IDLE && flit_valid) rem_d = rem_q - 7'd1;
    if (hdr_acc) begin
      cur_d.start = wr_ptr_q;
      cur_d.len   = h_len;
      cur_d.src   = h_src;
    end
    if (pl_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    // Same-cycle write and release both land: net change applied.
    used_d = used_q + (AW+1)'(pl_wr) - (pop ? (AW+1)'(head.len) : '0);
    rd_d   = pop  ? rd_q + FW'(1) : rd_q;
    wp_d   = push ? wp_q + FW'(1) : wp_q;
    cnt_d  = cnt_q + (FW+1)'(push) - (FW+1)'(pop);
    drop_d = ((hdr_bad || hdr_drop) && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    err_d  = hdr_bad || (desc_release && fifo_empty);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      used_q   <= '0;
      rem_q    <= '0;
      cur_q    <= '0;
      rd_q     <= '0;
      wp_q     <= '0;
      cnt_q    <= '0;
      drop_q   <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < NUM_MSGS; i++) fifo_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      used_q   <= used_d;
      rem_q    <= rem_d;
      cur_q    <= cur_d;
      rd_q     <= rd_d;
      wp_q     <= wp_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      err_q    <= err_d;
      if (push) fifo_q[wp_q] <= cur_q;
    end
  end

  assign buf_wen    = pl_wr;
  assign buf_waddr  = pl_wr ? wr_ptr_q : '0;
  assign buf_wdata  = pl_wr ? flit_data : '0;
  assign desc_valid = !fifo_empty;
  assign desc_start = head.start;
  assign desc_len   = head.len;
  assign desc_src   = head.src;
  assign drop_count = drop_q;
  assign err_pulse  = err_q;

endmodule

// File: tb/tb_endpoint_rx_fsm.sv
// Directed bench for endpoint_rx_fsm: stimulus queues expected writes/descriptors,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_endpoint_rx_fsm;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [4:0]  node_id = 5'd3;
  logic        flit_valid = 1'b0;
  logic [31:0] flit_data = '0;
  logic        flit_ready;
  logic        buf_wen;
  logic [6:0]  buf_waddr;
  logic [31:0] buf_wdata;
  logic        desc_valid;
  logic [6:0]  desc_start;
  logic [6:0]  desc_len;
  logic [4:0]  desc_src;
  logic        desc_release = 1'b0;
  logic [7:0]  drop_count;
  logic        err_pulse;

  endpoint_rx_fsm #(.BUF_WORDS(128), .NUM_MSGS(4), .MAX_PKT_WORDS(64)) dut (
    .clk(clk), .n_rst(n_rst), .node_id(node_id),
    .flit_valid(flit_valid), .flit_data(flit_data), .flit_ready(flit_ready),
    .buf_wen(buf_wen), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .desc_valid(desc_valid), .desc_start(desc_start), .desc_len(desc_len),
    .desc_src(desc_src), .desc_release(desc_release),
    .drop_count(drop_count), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  int ncmp = 0, nerr = 0;
  int          exp_waddr [$];
  logic [31:0] exp_wdata [$];
  int ed_start [$], ed_len [$], ed_src [$];
  int          m_a;
  logic [31:0] m_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input int d, input int s, input int l);
    return {4'h0, 5'(d), 5'(s), 7'(l), 11'h0};
  endfunction

  // Monitor: every write and every release is checked against the scoreboard.
  always @(negedge clk) begin
    if (buf_wen) begin
      if (exp_waddr.size() == 0) begin
        ncmp++; nerr++;
        $display("FAIL unexpected_write: addr %0d data %0h, none expected", buf_waddr, buf_wdata);
      end else begin
        m_a = exp_waddr.pop_front();
        m_d = exp_wdata.pop_front();
        chk("waddr", 32'(buf_waddr), 32'(m_a));
        chk("wdata", buf_wdata, m_d);
      end
    end
    if (desc_release) begin
      if (ed_start.size() != 0) begin
        chk("desc_valid_rel", 32'(desc_valid), 32'd1);
        chk("desc_start", 32'(desc_start), 32'(ed_start.pop_front()));
        chk("desc_len", 32'(desc_len), 32'(ed_len.pop_front()));
        chk("desc_src", 32'(desc_src), 32'(ed_src.pop_front()));
      end else begin
        chk("desc_valid_empty", 32'(desc_valid), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] d, input bit wr, input int addr);
    int n;
    if (wr) begin
      exp_waddr.push_back(addr);
      exp_wdata.push_back(d);
    end
    flit_valid = 1'b1;
    flit_data  = d;
    n = 0;
    @(negedge clk);
    while (!flit_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!flit_ready) begin
      ncmp++; nerr++;
      $display("FAIL flit_timeout: flit %0h never accepted", d);
    end
    tick();
    flit_valid = 1'b0;
    flit_data  = '0;
  endtask

  task automatic pkt(input int src, input int len, input int start, input logic [31:0] base);
    send(hdr(3, src, len), 1'b0, 0);
    for (int i = 0; i < len; i++) send(base + 32'(i), 1'b1, (start + i) % 128);
    ed_start.push_back(start); ed_len.push_back(len); ed_src.push_back(src);
  endtask

  task automatic rel();
    desc_release = 1'b1;
    tick();
    desc_release = 1'b0;
  endtask

  // Holds a header that must stall, then releases the head in the same cycle as a check.
  task automatic stall_then_release(input string nm, input logic [31:0] h);
    flit_valid = 1'b1;
    flit_data  = h;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk(nm, 32'(flit_ready), 32'd0);
      tick();
    end
    desc_release = 1'b1;
    @(negedge clk); chk(nm, 32'(flit_ready), 32'd0);
    tick();
    desc_release = 1'b0;
    @(negedge clk); chk({nm, "_go"}, 32'(flit_ready), 32'd1);
    tick();
    flit_valid = 1'b0;
    flit_data  = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_ready", 32'(flit_ready), 32'd0);
    chk("rst_desc_valid", 32'(desc_valid), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_err", 32'(err_pulse), 32'd0);
    chk("rst_wen", 32'(buf_wen), 32'd0);
    tick();
    n_rst = 1'b1;
    tick();

    // Good packet: writes 0..3, descriptor the cycle after the last flit
    send(hdr(3, 7, 4), 1'b0, 0);
    for (int i = 0; i < 3; i++) send(32'hA0 + 32'(i), 1'b1, i);
    @(negedge clk); chk("desc_early", 32'(desc_valid), 32'd0);
    tick();
    send(32'hA3, 1'b1, 3);
    ed_start.push_back(0); ed_len.push_back(4); ed_src.push_back(7);
    @(negedge clk);
    chk("t1_desc_valid", 32'(desc_valid), 32'd1);
    chk("t1_desc_start", 32'(desc_start), 32'd0);
    chk("t1_desc_len", 32'(desc_len), 32'd4);
    chk("t1_desc_src", 32'(desc_src), 32'd7);
    tick();

    // Misaddressed packet dropped, next header parsed normally
    send(hdr(5, 1, 2), 1'b0, 0);
    send(32'hB0, 1'b0, 0);
    send(32'hB1, 1'b0, 0);
    @(negedge clk); chk("drop_mis", 32'(drop_count), 32'd1);
    tick();
    pkt(2, 1, 4, 32'hC0);

    // Bad lengths: each header consumed alone
    send(hdr(3, 1, 0), 1'b0, 0);
    @(negedge clk); chk("err_len0", 32'(err_pulse), 32'd1);
    tick();
    @(negedge clk); chk("err_clear", 32'(err_pulse), 32'd0);
    tick();
    send(hdr(3, 1, 70), 1'b0, 0);
    @(negedge clk);
    chk("err_len70", 32'(err_pulse), 32'd1);
    chk("drop_badlen", 32'(drop_count), 32'd3);
    tick();
    @(negedge clk); chk("err_clear2", 32'(err_pulse), 32'd0);
    tick();

    // Reset mid-packet: two of four payload words written, then everything cleared
    send(hdr(3, 4, 4), 1'b0, 0);
    send(32'hD0, 1'b1, 5);
    send(32'hD1, 1'b1, 6);
    n_rst = 1'b0;
    ed_start.delete(); ed_len.delete(); ed_src.delete();
    @(negedge clk);
    chk("mrst_desc_valid", 32'(desc_valid), 32'd0);
    chk("mrst_drop", 32'(drop_count), 32'd0);
    chk("mrst_wen", 32'(buf_wen), 32'd0);
    tick();
    n_rst = 1'b1;
    tick();

    // Fill to used=126 from idx 0, then a len-4 header waits for space and wraps
    pkt(8, 64, 0, 32'h1000);
    pkt(9, 62, 64, 32'h2000);
    stall_then_release("stall_space", hdr(3, 10, 4));
    for (int i = 0; i < 4; i++) send(32'h3000 + 32'(i), 1'b1, (126 + i) % 128);
    ed_start.push_back(126); ed_len.push_back(4); ed_src.push_back(10);

    // Fill the descriptor FIFO, then a 5th header waits for a release
    pkt(11, 1, 2, 32'h4000);
    pkt(12, 1, 3, 32'h4100);
    stall_then_release("stall_full", hdr(3, 13, 1));
    send(32'h5000, 1'b1, 4);
    ed_start.push_back(4); ed_len.push_back(1); ed_src.push_back(13);
    @(negedge clk); chk("head_after_wrap", 32'(desc_start), 32'd126);
    tick();
    for (int i = 0; i < 4; i++) rel();
    rel();
    @(negedge clk); chk("err_rel_empty", 32'(err_pulse), 32'd1);
    tick();

    // drop_count saturation
    for (int i = 0; i < 260; i++) send(hdr(3, 0, 0), 1'b0, 0);
    @(negedge clk); chk("drop_sat", 32'(drop_count), 32'd255);
    tick();

    chk("writes_left", 32'(exp_waddr.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
